// File: rtl/read_logic_header_multi_if.sv
// Bus bundle for read_logic_header_multi: read/commit strobes, header register
// writes and the per-line read-side view. clk/rst stay outside the bundle.
interface read_logic_header_multi_if #(
    parameter int CHAR_WIDTH = 9,
    parameter int LINE_WIDTH = 3,
    parameter int VLAN_WIDTH = 4
) ();
    logic                             rd_char_incr;
    logic                             rd_newline;
    logic                             wr_commit;
    logic                             we_rgs;
    logic                             tlastarray_cs_rgs;
    logic [LINE_WIDTH+CHAR_WIDTH-1:0] wr_ptr_rgs;
    logic [7:0]                       tdata_rgs;

    logic [VLAN_WIDTH+CHAR_WIDTH-1:0] rd_ptr;
    logic [LINE_WIDTH-1:0]            rd_ptr_line;
    logic                             tlast_flag;
    logic [15:0]                      body_length;
    logic [LINE_WIDTH:0]              lines_avail;
    logic                             full;
    logic                             empty;
    logic                             ovf_err;
    logic                             unf_err;

    modport master (
        output rd_char_incr, rd_newline, wr_commit, we_rgs, tlastarray_cs_rgs,
               wr_ptr_rgs, tdata_rgs,
        input  rd_ptr, rd_ptr_line, tlast_flag, body_length, lines_avail,
               full, empty, ovf_err, unf_err
    );

    modport slave (
        input  rd_char_incr, rd_newline, wr_commit, we_rgs, tlastarray_cs_rgs,
               wr_ptr_rgs, tdata_rgs,
        output rd_ptr, rd_ptr_line, tlast_flag, body_length, lines_avail,
               full, empty, ovf_err, unf_err
    );
endinterface

// File: rtl/read_logic_header_multi.sv
// Read-side pointer and per-line header store for a multi-line packet buffer.
// Define READ_HDR_CHAR_CLAMP_EN to saturate the char offset instead of wrapping.
module read_logic_header_multi #(
    parameter int CHAR_WIDTH = 9,
    parameter int LINE_WIDTH = 3,
    parameter int VLAN_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    read_logic_header_multi_if.slave  bus
);
    localparam int DEPTH = 1 << LINE_WIDTH;
    localparam logic [LINE_WIDTH:0]   FULL_COUNT = {1'b1, {LINE_WIDTH{1'b0}}};
    localparam logic [LINE_WIDTH:0]   COUNT_ONE  = (LINE_WIDTH+1)'(1);
    localparam logic [LINE_WIDTH-1:0] LINE_ONE   = LINE_WIDTH'(1);
    localparam logic [CHAR_WIDTH-1:0] CHAR_ONE   = CHAR_WIDTH'(1);
`ifdef READ_HDR_CHAR_CLAMP_EN
    localparam logic [CHAR_WIDTH-1:0] CHAR_LAST  = '1;
`endif

    logic [CHAR_WIDTH-1:0] char_off;
    logic [CHAR_WIDTH-1:0] char_next;
    logic [LINE_WIDTH-1:0] line_idx;
    logic [LINE_WIDTH:0]   lines_avail;
    logic                  ovf_err;
    logic                  unf_err;
    logic                  is_full;
    logic                  is_empty;
    logic                  nl_accept;
    logic                  commit_accept;

    logic [LINE_WIDTH-1:0] wr_line;
    logic [CHAR_WIDTH-1:0] wr_off;

    logic                  tlast_mem   [DEPTH];
    logic [7:0]            body_hi_mem [DEPTH];
    logic [7:0]            body_lo_mem [DEPTH];
    logic [VLAN_WIDTH-1:0] vlan_mem    [DEPTH];

    assign wr_line = bus.wr_ptr_rgs[LINE_WIDTH+CHAR_WIDTH-1 -: LINE_WIDTH];
    assign wr_off  = bus.wr_ptr_rgs[CHAR_WIDTH-1:0];

    // A commit at full or a newline at empty still goes through when the
    // opposite event lands in the same cycle, judged on the pre-edge count.
    always_comb begin
        is_full       = (lines_avail == FULL_COUNT);
        is_empty      = (lines_avail == '0);
        nl_accept     = bus.rd_newline && (!is_empty || bus.wr_commit);
        commit_accept = bus.wr_commit && (!is_full || bus.rd_newline);
    end

    always_comb begin
        char_next = char_off;
        if (nl_accept) begin
            char_next = '0;
        end else if (bus.rd_char_incr && !bus.rd_newline) begin
`ifdef READ_HDR_CHAR_CLAMP_EN
            if (char_off != CHAR_LAST) begin
                char_next = char_off + CHAR_ONE;
            end
`else
            char_next = char_off + CHAR_ONE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            char_off    <= '0;
            line_idx    <= '0;
            lines_avail <= '0;
            ovf_err     <= 1'b0;
            unf_err     <= 1'b0;
        end else begin
            char_off <= char_next;
            if (nl_accept) begin
                line_idx <= line_idx + LINE_ONE;
            end
            if (commit_accept && !nl_accept) begin
                lines_avail <= lines_avail + COUNT_ONE;
            end else if (nl_accept && !commit_accept) begin
                lines_avail <= lines_avail - COUNT_ONE;
            end
            if (bus.wr_commit && !commit_accept) begin
                ovf_err <= 1'b1;
            end
            if (bus.rd_newline && !nl_accept) begin
                unf_err <= 1'b1;
            end
        end
    end

    // Header arrays carry no reset so their contents survive a pointer reset.
    always_ff @(posedge clk) begin
        if (!rst && bus.we_rgs) begin
            if (bus.tlastarray_cs_rgs) begin
                tlast_mem[wr_line] <= bus.tdata_rgs[0];
            end else begin
                case (wr_off)
                    CHAR_WIDTH'(0): body_hi_mem[wr_line] <= bus.tdata_rgs;
                    CHAR_WIDTH'(1): body_lo_mem[wr_line] <= bus.tdata_rgs;
                    CHAR_WIDTH'(2): vlan_mem[wr_line]    <= bus.tdata_rgs[VLAN_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign bus.rd_ptr      = {vlan_mem[line_idx], char_off};
    assign bus.rd_ptr_line = line_idx;
    assign bus.tlast_flag  = tlast_mem[line_idx];
    assign bus.body_length = {body_hi_mem[line_idx], body_lo_mem[line_idx]};
    assign bus.lines_avail = lines_avail;
    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.ovf_err     = ovf_err;
    assign bus.unf_err     = unf_err;
endmodule

// File: tb/tb_read_logic_header_multi.sv
// Scoreboard bench for read_logic_header_multi: directed scenarios then random traffic,
// checked against a line-buffer model. Honours READ_HDR_CHAR_CLAMP_EN like the design.
module tb_read_logic_header_multi;
    localparam int CW    = 9;
    localparam int LW    = 3;
    localparam int VW    = 4;
    localparam int DEPTH = 1 << LW;
    localparam int LINE_BYTES = 1 << CW;

    typedef struct {
        int char_off;
        int line;
        int avail;
        bit ovf;
        bit unf;
        bit tl_k;
        int tl;
        bit bh_k;
        int bh;
        bit bl_k;
        int bl;
        bit vp_k;
        int vp;
    } exp_t;

    logic clk;
    logic rst;

    read_logic_header_multi_if #(.CHAR_WIDTH(CW), .LINE_WIDTH(LW), .VLAN_WIDTH(VW)) bus ();

    read_logic_header_multi #(.CHAR_WIDTH(CW), .LINE_WIDTH(LW), .VLAN_WIDTH(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    int m_char  = 0;
    int m_line  = 0;
    int m_avail = 0;
    bit m_ovf   = 0;
    bit m_unf   = 0;
    int m_tl [DEPTH];
    int m_bh [DEPTH];
    int m_bl [DEPTH];
    int m_vp [DEPTH];
    bit k_tl [DEPTH];
    bit k_bh [DEPTH];
    bit k_bl [DEPTH];
    bit k_vp [DEPTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareField(input string name, input logic [31:0] act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("rd_ptr_char", {23'd0, bus.rd_ptr[CW-1:0]}, e.char_off);
        compareField("rd_ptr_line", {29'd0, bus.rd_ptr_line}, e.line);
        compareField("lines_avail", {28'd0, bus.lines_avail}, e.avail);
        compareField("full", {31'd0, bus.full}, (e.avail == DEPTH) ? 1 : 0);
        compareField("empty", {31'd0, bus.empty}, (e.avail == 0) ? 1 : 0);
        compareField("ovf_err", {31'd0, bus.ovf_err}, int'(e.ovf));
        compareField("unf_err", {31'd0, bus.unf_err}, int'(e.unf));
        if (e.tl_k) compareField("tlast_flag", {31'd0, bus.tlast_flag}, e.tl);
        if (e.bh_k) compareField("body_len_hi", {24'd0, bus.body_length[15:8]}, e.bh);
        if (e.bl_k) compareField("body_len_lo", {24'd0, bus.body_length[7:0]}, e.bl);
        if (e.vp_k) compareField("rd_ptr_vlan", {28'd0, bus.rd_ptr[VW+CW-1:CW]}, e.vp);
    endtask

    // One clock of stimulus; the model predicts what the outputs show after the edge.
    task automatic applyStimulus(input bit r, input bit incr, input bit nl, input bit cm,
                                 input bit we, input bit cs,
                                 input int wline, input int woff, input int wdata);
        exp_t e;
        bit   nl_acc;
        bit   cm_acc;
        @(negedge clk);
        rst                   = r;
        bus.rd_char_incr      = incr;
        bus.rd_newline        = nl;
        bus.wr_commit         = cm;
        bus.we_rgs            = we;
        bus.tlastarray_cs_rgs = cs;
        bus.wr_ptr_rgs        = {wline[LW-1:0], woff[CW-1:0]};
        bus.tdata_rgs         = wdata[7:0];

        if (r) begin
            m_char  = 0;
            m_line  = 0;
            m_avail = 0;
            m_ovf   = 0;
            m_unf   = 0;
        end else begin
            nl_acc = nl && (m_avail > 0 || cm);
            cm_acc = cm && (m_avail < DEPTH || nl);
            if (nl && !nl_acc) m_unf = 1;
            if (cm && !cm_acc) m_ovf = 1;
            m_avail = m_avail + int'(cm_acc) - int'(nl_acc);
            if (nl_acc) begin
                m_line = (m_line + 1) % DEPTH;
                m_char = 0;
            end else if (incr && !nl) begin
`ifdef READ_HDR_CHAR_CLAMP_EN
                if (m_char < LINE_BYTES - 1) m_char = m_char + 1;
`else
                m_char = (m_char + 1) % LINE_BYTES;
`endif
            end
            if (we) begin
                if (cs) begin
                    m_tl[wline] = wdata % 2;
                    k_tl[wline] = 1;
                end else if (woff == 0) begin
                    m_bh[wline] = wdata;
                    k_bh[wline] = 1;
                end else if (woff == 1) begin
                    m_bl[wline] = wdata;
                    k_bl[wline] = 1;
                end else if (woff == 2) begin
                    m_vp[wline] = wdata % (1 << VW);
                    k_vp[wline] = 1;
                end
            end
        end

        e.char_off = m_char;
        e.line     = m_line;
        e.avail    = m_avail;
        e.ovf      = m_ovf;
        e.unf      = m_unf;
        e.tl_k     = k_tl[m_line];
        e.tl       = m_tl[m_line];
        e.bh_k     = k_bh[m_line];
        e.bh       = m_bh[m_line];
        e.bl_k     = k_bl[m_line];
        e.bl       = m_bl[m_line];
        e.vp_k     = k_vp[m_line];
        e.vp       = m_vp[m_line];
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit incr, input bit nl, input bit cm);
        applyStimulus(r, incr, nl, cm, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic wrReg(input bit cs, input int line, input int off, input int data);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cs, line, off, data);
    endtask

    // Monitor: every edge that had stimulus behind it gets its prediction checked.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit r, incr, nl, cm, we, cs;
        rst                   = 1'b1;
        bus.rd_char_incr      = 1'b0;
        bus.rd_newline        = 1'b0;
        bus.wr_commit         = 1'b0;
        bus.we_rgs            = 1'b0;
        bus.tlastarray_cs_rgs = 1'b0;
        bus.wr_ptr_rgs        = '0;
        bus.tdata_rgs         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            k_tl[i] = 0; k_bh[i] = 0; k_bl[i] = 0; k_vp[i] = 0;
            m_tl[i] = 0; m_bh[i] = 0; m_bl[i] = 0; m_vp[i] = 0;
        end

        $display("[TB] reset and basic commit/read");
        repeat (2) cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 1);
        repeat (3) cyc(0, 0, 1, 0);

        $display("[TB] header write on line 2");
        wrReg(0, 2, 0, 'h05);
        wrReg(0, 2, 1, 'hDC);
        wrReg(0, 2, 2, 'h0A);
        wrReg(1, 2, 5, 1);
        repeat (7) cyc(0, 0, 1, 1);

        $display("[TB] char offset across a full line");
        repeat (LINE_BYTES) cyc(0, 1, 0, 0);

        $display("[TB] overflow and commit+newline at full");
        repeat (DEPTH + 1) cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);

        $display("[TB] underflow and newline+incr");
        repeat (DEPTH + 1) cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 1, 0);

        $display("[TB] reset mid-line keeps header arrays");
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 1);
        repeat (5) cyc(0, 0, 1, 0);
        repeat (100) cyc(0, 1, 0, 0);
        wrReg(0, 5, 0, 'h12);
        wrReg(0, 5, 1, 'h34);
        wrReg(0, 5, 2, 'h07);
        wrReg(1, 5, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 1);
        repeat (2) cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 1);
        repeat (3) cyc(0, 0, 1, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            r    = ($urandom_range(0, 199) == 0);
            incr = $urandom_range(0, 1) == 1;
            if (i < 1000) begin
                cm = ($urandom_range(0, 1) == 0);
                nl = ($urandom_range(0, 3) == 0);
            end else begin
                cm = ($urandom_range(0, 3) == 0);
                nl = ($urandom_range(0, 1) == 0);
            end
            we = !r && ($urandom_range(0, 2) == 0);
            cs = $urandom_range(0, 1) == 1;
            applyStimulus(r, incr, nl, cm, we, cs, int'($urandom_range(0, DEPTH - 1)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
        end

        @(negedge clk);
        bus.rd_char_incr = 1'b0;
        bus.rd_newline   = 1'b0;
        bus.wr_commit    = 1'b0;
        bus.we_rgs       = 1'b0;
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/read_logic_header_multi.md
READ_LOGIC_HEADER_MULTI -- requirements
Module: read_logic_header_multi

Interface
REQ-001 SHALL have parameter CHAR_WIDTH, default 9: char-offset counter width; one line = 2^CHAR_WIDTH bytes.
REQ-002 SHALL have parameter LINE_WIDTH, default 3: line-index width; buffer depth = 2^LINE_WIDTH lines.
REQ-003 SHALL have parameter VLAN_WIDTH, default 4: width of the per-line VLAN pointer.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port rd_char_incr  in  1  advance read char offset by one.
REQ-008 SHALL have port rd_newline  in  1  finish current line, advance to the next line.
REQ-009 SHALL have port wr_commit  in  1  writer has completed one line, making it readable.
REQ-010 SHALL have port we_rgs  in  1  header/flag register write strobe.
REQ-011 SHALL have port tlastarray_cs_rgs  in  1  1 = write targets tlast flag array, 0 = header bytes.
REQ-012 SHALL have port wr_ptr_rgs  in  LINE_WIDTH+CHAR_WIDTH  write address {line, byte offset}.
REQ-013 SHALL have port tdata_rgs  in  8  write data byte.
REQ-014 SHALL have port rd_ptr  out  VLAN_WIDTH+CHAR_WIDTH  {vlan_ptr of current line, char offset}.
REQ-015 SHALL have port rd_ptr_line  out  LINE_WIDTH  current read line index.
REQ-016 SHALL have port tlast_flag  out  1  tlast flag of current read line.
REQ-017 SHALL have port body_length  out  16  body length of current read line.
REQ-018 SHALL have port lines_avail  out  LINE_WIDTH+1  committed-but-unread line count.
REQ-019 SHALL have port full, empty  out  1 each  lines_avail == 2^LINE_WIDTH / == 0.
REQ-020 SHALL have port ovf_err, unf_err  out  1 each  sticky commit-when-full / newline-when-empty flags.

Function
REQ-021 SHALL, on rd_char_incr without rd_newline, increment the char offset modulo 2^CHAR_WIDTH (wrap, see REQ-034).
REQ-022 SHALL, on an accepted rd_newline, clear the char offset and increment the line index modulo 2^LINE_WIDTH; rd_newline wins over a simultaneous rd_char_incr.
REQ-023 SHALL accept rd_newline only when empty=0; otherwise leave the line index, char offset and lines_avail unchanged and set unf_err.
REQ-024 SHALL accept wr_commit only when full=0; otherwise leave lines_avail unchanged and set ovf_err.
REQ-025 SHALL update lines_avail: +1 on an accepted commit alone, -1 on an accepted newline alone, unchanged when both are accepted in the same cycle.
REQ-026 SHALL accept both a wr_commit at full and a rd_newline at empty when they coincide with the opposite event, evaluating full/empty on the pre-edge count.
REQ-027 SHALL, on we_rgs=1 with tlastarray_cs_rgs=1, write tdata_rgs[0] to the tlast flag of line wr_ptr_rgs[upper LINE_WIDTH bits].
REQ-028 SHALL, on we_rgs=1 with tlastarray_cs_rgs=0, write the header field of the addressed line selected by byte offset: 0 -> body_length[15:8], 1 -> body_length[7:0], 2 -> vlan_ptr = tdata_rgs[VLAN_WIDTH-1:0]; any other offset is ignored.
REQ-029 SHALL drive tlast_flag, body_length and the vlan_ptr field of rd_ptr combinationally from the register entry indexed by the current line index.
REQ-030 SHALL make a write to the currently read line visible on the outputs from the cycle after the write edge.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, clear the char offset, line index, lines_avail, ovf_err and unf_err; reset outputs are rd_ptr char field = 0, rd_ptr_line = 0, lines_avail = 0, empty = 1, full = 0.
REQ-032 SHALL NOT reset the tlast, body_length and vlan_ptr arrays; their contents are undefined until written.
REQ-033 SHALL give reset priority over every other input in the same cycle, including mid-line reads.

Configuration
REQ-034 SHALL, when macro READ_HDR_CHAR_CLAMP_EN is defined, saturate the char offset at 2^CHAR_WIDTH-1 (further rd_char_incr ignored until rd_newline); when undefined, the offset wraps to 0.

Verification
REQ-035 SHALL cover: reset, then 3 wr_commit -> lines_avail=3, empty=0; 3 rd_newline -> rd_ptr_line=3, lines_avail=0, empty=1.
REQ-036 SHALL cover: write line 2 offsets 0/1/2 = 0x05/0xDC/0x0A, tlast=1, advance to line 2 -> body_length=0x05DC, rd_ptr[12:9]=0xA, tlast_flag=1.
REQ-037 SHALL cover: 512 rd_char_incr on a line -> offset 0 without clamp macro, 511 with READ_HDR_CHAR_CLAMP_EN.
REQ-038 SHALL cover: 8 commits (full=1), 9th commit -> lines_avail stays 8, ovf_err=1; commit+newline same cycle at full -> lines_avail=8, line index +1.
REQ-039 SHALL cover: rd_newline at empty -> unf_err=1, rd_ptr_line unchanged; rd_newline+rd_char_incr same cycle with lines_avail=1 -> offset 0.
REQ-040 SHALL cover: rst asserted mid-line with offset=100, line=5 -> next cycle offset 0, line 0, lines_avail 0, header arrays retain written values.
